touch_spi_reader: RTL and testbench

TOUCH_SPI_READER -- requirements
Module: touch_spi_reader

---
 rtl/touch_pkg.sv | 23 ++
 rtl/touch_sck_tick.sv | 44 ++++
 rtl/touch_spi_reader.sv | 160 ++++++++++++++++
 tb/tb_touch_spi_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch-controller SPI reader.
// Holds the FSM state encoding, default command bytes and frame/result widths.
package touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_X_DEFAULT = 8'hD0;
    localparam logic [7:0] CMD_Y_DEFAULT = 8'h90;

    localparam int CMD_W      = 8;
    localparam int FRAME_BITS = 24;
    localparam int RX_W       = 16;
    localparam int RESULT_W   = 12;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/touch_sck_tick.sv
// SCK generator: DIV-cycle half-period divider with one-cycle tick/rise/fall strobes.
// The strobes mark the clk_100M edge on which the divider wraps or SCK changes.
module touch_sck_tick
    import touch_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic en,
    input  logic sck_run,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);
    assign rise = tick && sck_run && !sck;
    assign fall = tick && sck_run && sck;

    // Counter restarts from zero whenever the FSM leaves the timed states, so
    // every timed phase starts aligned and wraps cleanly without drift.
    always_ff @(posedge clk_100M or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (!sck_run)
                sck <= 1'b0;
            else if (tick)
                sck <= ~sck;
        end
    end

endmodule

// File: rtl/touch_spi_reader.sv
// Reads one X and one Y 12-bit sample from a resistive-touch controller over SPI.
// Two 24-SCK frames per request; a pen release mid-read finishes the frame and returns valid=0.
module touch_spi_reader
    import touch_pkg::*;
#(
    parameter int         DIV   = 50,
    parameter logic [7:0] CMD_X = CMD_X_DEFAULT,
    parameter logic [7:0] CMD_Y = CMD_Y_DEFAULT
) (
    input  logic                clk_100M,
    input  logic                rst,
    input  logic                start,
    input  logic                penDown_n,
    input  logic                spi_miso,
    output logic                spi_sck,
    output logic                spi_cs_n,
    output logic                spi_mosi,
    output logic                busy,
    output logic                done,
    output logic                valid,
    output logic [RESULT_W-1:0] x,
    output logic [RESULT_W-1:0] y
);

    localparam logic [4:0] LAST_PERIOD = 5'(FRAME_BITS - 1);
    localparam logic [4:0] FIRST_RX    = 5'(FRAME_BITS - RX_W);

    state_t state, state_next;

    logic                en, sck_run, tick, rise, fall;
    logic                load_cmd, sel_y, accept, abort_any;
    logic                frame_y, aborted;
    logic [4:0]          bit_cnt;
    logic [CMD_W-1:0]    mosi_sr;
    logic [RX_W-1:0]     rx;
    logic [RESULT_W-1:0] x_buf;
    logic [RESULT_W-1:0] rx_result;

    assign abort_any = aborted | penDown_n;
    assign spi_mosi  = mosi_sr[CMD_W-1];
    // Drop the leading busy bit and the three trailing zeros.
    assign rx_result = rx[RX_W-2 -: RESULT_W];

    touch_sck_tick #(.DIV(DIV)) u_sck_tick (
        .clk_100M (clk_100M),
        .rst      (rst),
        .en       (en),
        .sck_run  (sck_run),
        .sck      (spi_sck),
        .tick     (tick),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk_100M or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        en         = 1'b0;
        sck_run    = 1'b0;
        load_cmd   = 1'b0;
        sel_y      = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                // The done cycle is already IDLE, so exclude it explicitly.
                if (start && !penDown_n && !done) begin
                    accept     = 1'b1;
                    load_cmd   = 1'b1;
                    state_next = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                en = 1'b1;
                if (tick)
                    state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                en      = 1'b1;
                sck_run = 1'b1;
                if (fall && bit_cnt == LAST_PERIOD)
                    state_next = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                en = 1'b1;
                if (tick)
                    state_next = (!frame_y && !abort_any) ? ST_GAP : ST_DONE;
            end
            ST_GAP: begin
                en = 1'b1;
                if (tick) begin
                    if (abort_any) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_CS_SETUP;
                        load_cmd   = 1'b1;
                        sel_y      = 1'b1;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or negedge rst) begin
        if (!rst) begin
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            x        <= '0;
            y        <= '0;
            bit_cnt  <= '0;
            mosi_sr  <= '0;
            rx       <= '0;
            x_buf    <= '0;
            frame_y  <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            spi_cs_n <= !(state_next inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
            busy     <= (state_next != ST_IDLE);
            done     <= (state == ST_DONE);

            if (load_cmd) begin
                mosi_sr <= sel_y ? CMD_Y : CMD_X;
                bit_cnt <= '0;
                frame_y <= sel_y;
            end else if (fall) begin
                mosi_sr <= {mosi_sr[CMD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (rise && bit_cnt >= FIRST_RX)
                rx <= {rx[RX_W-2:0], spi_miso};

            if (state == ST_CS_HOLD && tick && !frame_y)
                x_buf <= rx_result;

            if (accept) begin
                aborted <= 1'b0;
                valid   <= 1'b0;
            end else if (state == ST_DONE) begin
                valid <= !abort_any;
                if (!abort_any) begin
                    x <= x_buf;
                    y <= rx_result;
                end
            end else if (state != ST_IDLE && penDown_n) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_touch_spi_reader.sv
// Scoreboard bench for touch_spi_reader: controller model on MISO, frame and done monitors,
// randomized reads with pen releases, start spam and mid-frame reset; second instance at DIV=2.
module tb_touch_spi_reader;

    localparam int DIV   = 4;
    localparam int DIV2  = 2;
    localparam int LIMIT = 1000;

    logic clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        penDown_n = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_sck, spi_cs_n, spi_mosi, busy, done, valid;
    logic [11:0] x, y;

    logic        start2 = 1'b0;
    logic        sck2, cs_n2, mosi2, busy2, done2, valid2;
    logic [11:0] x2, y2;

    touch_spi_reader #(.DIV(DIV)) u_dut (
        .clk_100M (clk_100M), .rst (rst), .start (start), .penDown_n (penDown_n),
        .spi_miso (spi_miso), .spi_sck (spi_sck), .spi_cs_n (spi_cs_n), .spi_mosi (spi_mosi),
        .busy (busy), .done (done), .valid (valid), .x (x), .y (y)
    );

    touch_spi_reader #(.DIV(DIV2)) u_dut2 (
        .clk_100M (clk_100M), .rst (rst), .start (start2), .penDown_n (1'b0),
        .spi_miso (1'b1), .spi_sck (sck2), .spi_cs_n (cs_n2), .spi_mosi (mosi2),
        .busy (busy2), .done (done2), .valid (valid2), .x (x2), .y (y2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic        vld;
        logic [11:0] ex;
        logic [11:0] ey;
        int          done_at;
    } txn_t;

    txn_t        txn_q[$];
    logic [7:0]  frame_q[$];
    logic [11:0] model_x = '0, model_y = '0;
    logic [11:0] xval = '0, yval = '0;

    // Controller response for the k-th SCK rise of a frame: busy bit at rise 9,
    // 12 data bits MSB first at rises 10..21, zeros elsewhere.
    function automatic logic resp_bit(input logic [7:0] c, input int k);
        logic [11:0] v;
        v = (c == 8'hD0) ? xval : (c == 8'h90) ? yval : 12'h000;
        if (k >= 10 && k <= 21)
            return v[21-k];
        return 1'b0;
    endfunction

    // SPI monitor and MISO driver, sampled on the falling clk edge.
    logic        prev_cs = 1'b1, prev_sck = 1'b0, have_frame = 1'b0;
    int          rises = 0, gap_cnt = 0;
    logic [23:0] mword = '0;
    logic [7:0]  cmd_seen = '0;
    logic [7:0]  exp_cmd;

    always @(negedge clk_100M) begin
        if (!rst) begin
            frame_q.delete();
            prev_cs    = 1'b1;
            prev_sck   = 1'b0;
            have_frame = 1'b0;
            spi_miso   = 1'b0;
        end else begin
            if (!spi_cs_n && prev_cs) begin
                if (have_frame)
                    check("cs_gap_ge_div", 32'(gap_cnt >= DIV), 32'd1);
                rises    = 0;
                mword    = '0;
                spi_miso = 1'b0;
            end
            if (spi_cs_n && !prev_cs) begin
                if (frame_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_cmd = frame_q.pop_front();
                    check("mosi_frame", 32'(mword), 32'({exp_cmd, 16'h0000}));
                end
                check("sck_rises", 32'(rises), 32'd24);
                have_frame = 1'b1;
                gap_cnt    = 0;
            end
            if (spi_cs_n)
                gap_cnt++;
            if (!spi_cs_n && spi_sck && !prev_sck) begin
                rises++;
                mword = {mword[22:0], spi_mosi};
                if (rises == 8)
                    cmd_seen = mword[7:0];
            end
            if (!spi_cs_n && !spi_sck && prev_sck)
                spi_miso = resp_bit(cmd_seen, rises + 1);
            prev_cs  = spi_cs_n;
            prev_sck = spi_sck;
        end
    end

    // Done monitor: pops the expected result whenever the DUT pulses done.
    txn_t t;
    always @(negedge clk_100M) begin
        if (rst && done) begin
            if (txn_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                t = txn_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(t.done_at));
                check("valid", 32'(valid), 32'(t.vld));
                check("x", 32'(x), 32'(t.ex));
                check("y", 32'(y), 32'(t.ey));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // One read request; release_at >= 0 raises penDown_n that many cycles after acceptance.
    task automatic do_read(input logic [11:0] xv, input logic [11:0] yv,
                           input int release_at, input bit spam);
        txn_t n;
        int   acc;
        bit   seen;
        xval = xv;
        yval = yv;
        @(negedge clk_100M);
        start = 1'b1;
        @(posedge clk_100M);
        #1;
        start = 1'b0;
        acc   = cyc;
        if (release_at < 0) begin
            frame_q.push_back(8'hD0);
            frame_q.push_back(8'h90);
            n.vld = 1'b1; n.ex = xv; n.ey = yv;
            n.done_at = acc + 2 * 50 * DIV + DIV + 1;
            model_x = xv;
            model_y = yv;
        end else begin
            frame_q.push_back(8'hD0);
            n.vld = 1'b0; n.ex = model_x; n.ey = model_y;
            n.done_at = acc + 50 * DIV + 1;
        end
        txn_q.push_back(n);
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_100M);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (i == release_at)
                penDown_n = 1'b1;
            if (spam && (i % 7) == 3)
                start = 1'b1;
        end
        if (!seen)
            check("done_timeout", 32'd0, 32'd1);
        penDown_n = 1'b0;
        start     = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc2;
        bit  seen;
        bit  saw_busy, saw_cs;

        repeat (3) @(negedge clk_100M);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_xy", 32'({x, y}), 32'd0);
        check("rst2_outputs", 32'({cs_n2, sck2, mosi2, busy2, done2, valid2}), 32'b100000);
        check("rst2_xy", 32'({x2, y2}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk_100M);

        do_read(12'hABC, 12'h123, -1, 1'b0);

        // Start with the pen up must be ignored entirely.
        penDown_n = 1'b1;
        start     = 1'b1;
        @(negedge clk_100M);
        start    = 1'b0;
        saw_busy = 1'b0;
        saw_cs   = 1'b0;
        repeat (30) begin
            @(negedge clk_100M);
            saw_busy |= busy;
            saw_cs   |= !spi_cs_n;
        end
        check("penup_busy", 32'(saw_busy), 32'd0);
        check("penup_cs", 32'(saw_cs), 32'd0);
        penDown_n = 1'b0;

        do_read(12'($urandom), 12'($urandom), 80, 1'b0);
        do_read(12'($urandom), 12'($urandom), -1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk_100M);
            do_read(12'($urandom), 12'($urandom),
                    (($urandom % 3) == 0) ? int'($urandom_range(5, 190)) : -1,
                    1'($urandom));
        end

        // Reset in the middle of the X frame's SHIFT phase.
        @(negedge clk_100M);
        start = 1'b1;
        @(posedge clk_100M);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk_100M);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        check("midrst_sck", 32'(spi_sck), 32'd0);
        check("midrst_others", 32'({spi_mosi, busy, done, valid}), 32'd0);
        check("midrst_xy", 32'({x, y}), 32'd0);
        model_x = '0;
        model_y = '0;
        repeat (3) @(negedge clk_100M);
        rst = 1'b1;
        repeat (500) @(negedge clk_100M);
        do_read(12'($urandom), 12'($urandom), -1, 1'b0);

        // DIV=2 instance with MISO tied high.
        @(negedge clk_100M);
        start2 = 1'b1;
        @(posedge clk_100M);
        #1;
        start2 = 1'b0;
        acc2   = cyc;
        seen   = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk_100M);
            if (done2) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            check("div2_done_cycle", 32'(cyc - acc2), 32'(101 * DIV2 + 1));
            check("div2_valid", 32'(valid2), 32'd1);
            check("div2_x", 32'(x2), 32'hFFF);
            check("div2_y", 32'(y2), 32'hFFF);
        end else begin
            check("div2_done_timeout", 32'd0, 32'd1);
        end

        repeat (5) @(negedge clk_100M);
        check("txn_queue_drained", 32'(txn_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frame_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
